branch_redirect_ctrl: RTL and testbench

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_ctrl_pkg.sv | 25 ++
 rtl/branch_bht.sv | 34 +++
 rtl/branch_redirect_ctrl.sv | 97 +++++++++
 tb/tb_branch_redirect_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller and its predictor table.
package branch_redirect_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [1:0]  CTR_RESET = 2'b01;
    localparam int unsigned CTR_W     = 2;
    localparam int unsigned CNT_W     = 32;

    // Saturating 2-bit counter step toward taken/not-taken.
    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr, input logic taken);
        logic [CTR_W-1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + CTR_W'(1);
        end else begin
            if (ctr != 2'b00) res = ctr - CTR_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters, one lookup port and one update port.
module branch_bht
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    logic [CTR_W-1:0] ctr [ENTRIES];

    // Counter storage; reset to weakly not-taken, train on update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr[i] <= CTR_RESET;
            end
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
        end
    end

    // Lookup reads the stored value, so a same-cycle update is not visible yet.
    assign lookup_taken = ctr[lookup_idx][1];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolve / mispredict redirect controller with a small bimodal predictor.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WITDH = 32,
    parameter int unsigned BHT_IDX    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  ex_is_br,
    input  logic                  ex_taken,
    input  logic                  ex_pred_taken,
    input  logic [DATA_WITDH-1:0] ex_pc,
    input  logic [DATA_WITDH-1:0] ex_target,
    input  logic [DATA_WITDH-1:0] if_pc,
    output logic                  pred_taken,
    output logic                  redir_valid,
    input  logic                  redir_ready,
    output logic [DATA_WITDH-1:0] redir_pc,
    output logic                  flush,
    output logic                  stall,
    output logic [CNT_W-1:0]      mispred_cnt
);

    state_t state;
    state_t state_nxt;
    logic   resolve;
    logic   mispredict;
    logic   unused_if_pc_bits;

    assign resolve    = ex_valid && (state == ST_IDLE);
    assign mispredict = resolve && (ex_taken != ex_pred_taken);

    // Fetch PC bits outside the table index carry no information for the predictor.
    assign unused_if_pc_bits = ^{if_pc[DATA_WITDH-1:BHT_IDX+2], if_pc[1:0]};

    // Predictor table; only conditional branches train it.
    branch_bht #(
        .IDX_W (BHT_IDX)
    ) u_bht (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_idx   (if_pc[BHT_IDX+1:2]),
        .lookup_taken (pred_taken),
        .upd_en       (resolve && ex_is_br),
        .upd_idx      (ex_pc[BHT_IDX+1:2]),
        .upd_taken    (ex_taken)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: enter HOLD on mispredict, leave on redirect handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mispredict) state_nxt = ST_HOLD;
            ST_HOLD: if (redir_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        redir_valid = 1'b0;
        stall       = 1'b0;
        if (state == ST_HOLD) begin
            redir_valid = 1'b1;
            stall       = 1'b1;
        end
    end

    // Redirect target, first-HOLD-cycle flush pulse and mispredict counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_pc    <= '0;
            flush       <= 1'b0;
            mispred_cnt <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                redir_pc <= ex_taken ? ex_target : ex_pc + DATA_WITDH'(4);
                if (mispred_cnt != '1) begin
                    mispred_cnt <= mispred_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: reference model + scoreboard queue.
module tb_branch_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_is_br;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush;
    logic        stall;
    logic [31:0] mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        valid;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    bit          m_hold;
    int          m_ctr [16];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    branch_redirect_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_is_br      (ex_is_br),
        .ex_taken      (ex_taken),
        .ex_pred_taken (ex_pred_taken),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .redir_valid   (redir_valid),
        .redir_ready   (redir_ready),
        .redir_pc      (redir_pc),
        .flush         (flush),
        .stall         (stall),
        .mispred_cnt   (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    task automatic model_reset();
        m_hold = 0;
        m_pc   = 32'h0;
        m_cnt  = 32'h0;
        for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    endtask

    // One cycle: drive inputs, check lookup, advance model, queue expected registered outputs.
    task automatic step(input logic v, input logic br, input logic tk, input logic pt,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [31:0] ipc, input logic rdy);
        bit resolve;
        bit mis;
        bit fl;
        int i;
        exp_t e;
        @(negedge clk);
        #2;
        ex_valid = v; ex_is_br = br; ex_taken = tk; ex_pred_taken = pt;
        ex_pc = pc; ex_target = tgt; if_pc = ipc; redir_ready = rdy;
        #1;
        chk("pred_taken", 32'(pred_taken), 32'(m_ctr[idx_of(ipc)] >= 2));
        chk("stall", 32'(stall), 32'(m_hold));
        resolve = v && !m_hold;
        mis     = resolve && (tk != pt);
        if (resolve && br) begin
            i = idx_of(pc);
            if (tk) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
        fl = 0;
        if (mis) begin
            fl     = 1;
            m_hold = 1;
            m_pc   = tk ? tgt : pc + 32'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (m_hold && rdy) begin
            m_hold = 0;
        end
        e.valid = m_hold; e.flush = fl; e.pc = m_pc; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic rdy);
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h100, rdy);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; ex_valid = 1'b0;
        #1;
        chk("rst redir_valid", 32'(redir_valid), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst flush", 32'(flush), 32'd0);
        chk("rst mispred_cnt", mispred_cnt, 32'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: pop one expectation per cycle and compare registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("redir_valid", 32'(redir_valid), 32'(e.valid));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("redir_pc", redir_pc, e.pc);
                chk("mispred_cnt", mispred_cnt, e.cnt);
                chk("stall_mon", 32'(stall), 32'(e.valid));
            end
        end
    end

    initial begin
        int budget;
        rst_n = 1'b0; ex_valid = 0; ex_is_br = 0; ex_taken = 0; ex_pred_taken = 0;
        ex_pc = 0; ex_target = 0; if_pc = 32'h100; redir_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("reset pred_taken", 32'(pred_taken), 32'd0);
        chk("reset redir_valid", 32'(redir_valid), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset flush", 32'(flush), 32'd0);
        chk("reset redir_pc", redir_pc, 32'd0);
        chk("reset mispred_cnt", mispred_cnt, 32'd0);

        // Taken mispredict with ready high: one-cycle HOLD.
        step(1, 1, 1, 0, 32'h100, 32'h80, 32'h100, 1);
        idle(1);
        idle(1);

        // Not-taken mispredict, ready low for 3 cycles.
        step(1, 1, 0, 1, 32'h200, 32'h999, 32'h200, 0);
        idle(0); idle(0); idle(0);
        idle(1);
        idle(1);

        // Training at 0x140; 0x180 aliases to the same entry.
        step(1, 1, 1, 1, 32'h140, 32'h40, 32'h180, 1);
        step(1, 1, 1, 1, 32'h140, 32'h40, 32'h140, 1);
        step(1, 1, 1, 1, 32'h140, 32'h40, 32'h140, 1);
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h180, 1);
        // jal-style taken without ex_is_br does not train.
        step(1, 0, 1, 1, 32'h300, 32'h40, 32'h300, 1);
        idle(1);

        // ex_valid during HOLD is ignored.
        step(1, 1, 1, 0, 32'h140, 32'h500, 32'h140, 0);
        step(1, 1, 0, 1, 32'h140, 32'h0, 32'h140, 0);
        step(1, 1, 0, 0, 32'h140, 32'h0, 32'h140, 0);
        step(1, 1, 1, 0, 32'h140, 32'h0, 32'h140, 1);
        idle(1);

        // pc+4 wraps.
        step(1, 1, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1);
        // Back-to-back resolve after one-cycle HOLD.
        step(1, 1, 0, 1, 32'h10, 32'h0, 32'h10, 1);
        step(1, 1, 1, 0, 32'h20, 32'h1234, 32'h20, 1);
        idle(1);
        idle(1);

        // Reset during HOLD abandons the redirect.
        step(1, 1, 1, 0, 32'h140, 32'h700, 32'h140, 0);
        idle(0);
        do_reset();
        idle(1);
        idle(1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            logic [31:0] ipc;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 255)) << 2;
                ipc = 32'($urandom_range(0, 255)) << 2;
                step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) != 0),
                     1'($urandom), 1'($urandom), pc, $urandom & 32'hFFFF_FFFC, ipc,
                     1'($urandom));
            end
        end

        // Drain the scoreboard with a bounded wait.
        idle(1);
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
